fetch_arbiter: RTL and testbench



---
 rtl/fetch_arbiter_if.sv | 26 ++
 rtl/fetch_arbiter.sv | 134 +++++++++++++
 tb/tb_fetch_arbiter.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/fetch_arbiter_if.sv
// Fetch-arbiter bus: per-core fetcher read channels plus the shared program-memory read port.
// The arbiter side uses the master modport; the fetchers/memory side uses slave.
interface fetch_arbiter_if #(
  parameter int NUM_CONSUMERS = 4,
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 16
);
  logic [NUM_CONSUMERS-1:0]           consumer_read_valid;
  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address;
  logic [NUM_CONSUMERS-1:0]           consumer_read_ready;
  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data;
  logic                               mem_read_valid;
  logic [ADDR_BITS-1:0]               mem_read_address;
  logic                               mem_read_ready;
  logic [DATA_BITS-1:0]               mem_read_data;

  modport master (
    input  consumer_read_valid, consumer_read_address, mem_read_ready, mem_read_data,
    output consumer_read_ready, consumer_read_data, mem_read_valid, mem_read_address
  );

  modport slave (
    output consumer_read_valid, consumer_read_address, mem_read_ready, mem_read_data,
    input  consumer_read_ready, consumer_read_data, mem_read_valid, mem_read_address
  );
endinterface

// File: rtl/fetch_arbiter.sv
// Round-robin arbiter sharing one program-memory read port among NUM_CONSUMERS fetchers.
// Optional FETCH_ARB_BROADCAST_EN: a response also serves other waiting channels with the same address.
module fetch_arbiter #(
  parameter int NUM_CONSUMERS = 4,
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 16
) (
  input  logic           clk,
  input  logic           reset,
  fetch_arbiter_if.master bus
);
  localparam int PTR_W = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAITING  = 2'd1,
    RELAYING = 2'd2
  } state_t;

  state_t                             state_r;
  logic [PTR_W-1:0]                   rr_ptr_r;
  logic [PTR_W-1:0]                   grant_r;
  logic [NUM_CONSUMERS-1:0]           served_r;
  logic [NUM_CONSUMERS-1:0]           ready_r;
  logic [NUM_CONSUMERS*DATA_BITS-1:0] data_r;
  logic                               mem_valid_r;
  logic [ADDR_BITS-1:0]               mem_addr_r;

  logic [ADDR_BITS-1:0]               addr_s [NUM_CONSUMERS];
  logic [NUM_CONSUMERS-1:0]           valid_rot_s;
  logic                               found_s;
  logic [PTR_W-1:0]                   pick_s;
  logic [ADDR_BITS-1:0]               pick_addr_s;
  logic [NUM_CONSUMERS-1:0]           served_set_s;
  logic [NUM_CONSUMERS-1:0]           ready_keep_s;

  assign bus.consumer_read_ready = ready_r;
  assign bus.consumer_read_data  = data_r;
  assign bus.mem_read_valid      = mem_valid_r;
  assign bus.mem_read_address    = mem_addr_r;

  // Next-grant search, served-set formation and ready release.
  always_comb begin
    for (int i = 0; i < NUM_CONSUMERS; i++) begin
      addr_s[i] = bus.consumer_read_address[i*ADDR_BITS +: ADDR_BITS];
    end

    // Rotating by rr_ptr makes bit 0 the highest-priority channel.
    valid_rot_s = NUM_CONSUMERS'({bus.consumer_read_valid, bus.consumer_read_valid} >> rr_ptr_r);
    found_s     = 1'b0;
    pick_s      = {PTR_W{1'b0}};
    for (int k = 0; k < NUM_CONSUMERS; k++) begin
      if (!found_s && valid_rot_s[k]) begin
        found_s = 1'b1;
        pick_s  = PTR_W'((int'(rr_ptr_r) + k) % NUM_CONSUMERS);
      end else begin
        pick_s  = pick_s;
      end
    end

    pick_addr_s = addr_s[0];
    for (int i = 0; i < NUM_CONSUMERS; i++) begin
      if (PTR_W'(i) == pick_s) begin
        pick_addr_s = addr_s[i];
      end else begin
        pick_addr_s = pick_addr_s;
      end
    end

    for (int i = 0; i < NUM_CONSUMERS; i++) begin
      served_set_s[i] = (PTR_W'(i) == grant_r);
`ifdef FETCH_ARB_BROADCAST_EN
      served_set_s[i] = served_set_s[i] |
                        (bus.consumer_read_valid[i] & (addr_s[i] == mem_addr_r));
`endif
    end

    ready_keep_s = ready_r & ~(served_r & ~bus.consumer_read_valid);
  end

  // Arbitration FSM with registered memory request and per-channel responses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      rr_ptr_r    <= {PTR_W{1'b0}};
      grant_r     <= {PTR_W{1'b0}};
      served_r    <= {NUM_CONSUMERS{1'b0}};
      ready_r     <= {NUM_CONSUMERS{1'b0}};
      data_r      <= {(NUM_CONSUMERS*DATA_BITS){1'b0}};
      mem_valid_r <= 1'b0;
      mem_addr_r  <= {ADDR_BITS{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (found_s) begin
            grant_r     <= pick_s;
            mem_addr_r  <= pick_addr_s;
            mem_valid_r <= 1'b1;
            state_r     <= WAITING;
          end
        end
        WAITING: begin
          if (bus.mem_read_ready) begin
            mem_valid_r <= 1'b0;
            for (int i = 0; i < NUM_CONSUMERS; i++) begin
              if (served_set_s[i]) begin
                data_r[i*DATA_BITS +: DATA_BITS] <= bus.mem_read_data;
              end
            end
            ready_r  <= served_set_s;
            served_r <= served_set_s;
            state_r  <= RELAYING;
          end
        end
        RELAYING: begin
          ready_r <= ready_keep_s;
          // The channel just served drops to lowest priority.
          if (ready_keep_s == {NUM_CONSUMERS{1'b0}}) begin
            rr_ptr_r <= (grant_r == PTR_W'(NUM_CONSUMERS - 1)) ? {PTR_W{1'b0}}
                                                                : grant_r + PTR_W'(1);
            served_r <= {NUM_CONSUMERS{1'b0}};
            state_r  <= IDLE;
          end
        end
        default: begin
          state_r     <= IDLE;
          ready_r     <= {NUM_CONSUMERS{1'b0}};
          served_r    <= {NUM_CONSUMERS{1'b0}};
          mem_valid_r <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_arbiter.sv
// Directed bench for fetch_arbiter: table of transactions plus hand-written stall,
// early-drop and reset sequences; memory responses are driven by the bench.
module tb_fetch_arbiter;
  localparam int N = 4;
  localparam int A = 8;
  localparam int D = 16;

  typedef struct {
    logic [N-1:0]   valid;
    logic [N*A-1:0] addrs;
    logic [D-1:0]   mdata;
    logic [A-1:0]   exp_addr;
    logic [N-1:0]   exp_ready;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   checks_total = 0;
  int   checks_passed = 0;
  logic [N*D-1:0] exp_bus;
  vec_t vecs [12];
  int   n_vec;

  fetch_arbiter_if #(.NUM_CONSUMERS(N), .ADDR_BITS(A), .DATA_BITS(D)) bus ();

  fetch_arbiter #(.NUM_CONSUMERS(N), .ADDR_BITS(A), .DATA_BITS(D)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks_total++;
    if (act === exp) checks_passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, " mem_valid"}, 64'(bus.mem_read_valid), 64'(1'b0));
    check({name, " mem_addr"}, 64'(bus.mem_read_address), 64'(8'h00));
    check({name, " ready"}, 64'(bus.consumer_read_ready), 64'(4'b0000));
    check({name, " data"}, 64'(bus.consumer_read_data), 64'(exp_bus));
  endtask

  // Raise requests and wait (bounded) for the memory request.
  task automatic start_txn(input logic [N-1:0] v, input logic [N*A-1:0] a,
                           input logic [A-1:0] exp_addr, input string name);
    bit seen = 1'b0;
    bus.consumer_read_valid   = v;
    bus.consumer_read_address = a;
    bus.mem_read_ready        = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      tick();
      if (bus.mem_read_valid === 1'b1) seen = 1'b1;
    end
    check({name, " request issued"}, 64'(seen), 64'(1'b1));
    check({name, " mem addr"}, 64'(bus.mem_read_address), 64'(exp_addr));
    check({name, " no early ready"}, 64'(bus.consumer_read_ready), 64'(4'b0000));
  endtask

  // Deliver a one-cycle memory response, check relay, then let served fetchers drop valid.
  task automatic finish_txn(input logic [D-1:0] d, input logic [N-1:0] exp_ready,
                            input string name);
    bus.mem_read_ready = 1'b1;
    bus.mem_read_data  = d;
    tick();
    bus.mem_read_ready = 1'b0;
    for (int i = 0; i < N; i++) if (exp_ready[i]) exp_bus[i*D +: D] = d;
    check({name, " mem valid drop"}, 64'(bus.mem_read_valid), 64'(1'b0));
    check({name, " ready"}, 64'(bus.consumer_read_ready), 64'(exp_ready));
    check({name, " data"}, 64'(bus.consumer_read_data), 64'(exp_bus));
    bus.consumer_read_valid = bus.consumer_read_valid & ~exp_ready;
    tick();
    check({name, " ready release"}, 64'(bus.consumer_read_ready), 64'(4'b0000));
  endtask

  task automatic run_vec(input int idx);
    string name;
    name = $sformatf("vec%0d", idx);
    start_txn(vecs[idx].valid, vecs[idx].addrs, vecs[idx].exp_addr, name);
    finish_txn(vecs[idx].mdata, vecs[idx].exp_ready, name);
  endtask

  initial begin
    // Single request, then ch3 to bring the pointer back to 0, then round-robin.
    vecs[0] = '{4'b0100, 32'h0010_0000, 16'hABCD, 8'h10, 4'b0100};
    vecs[1] = '{4'b1000, 32'h4400_0000, 16'h4444, 8'h44, 4'b1000};
    vecs[2] = '{4'b1111, 32'h0C08_0400, 16'h1111, 8'h00, 4'b0001};
    vecs[3] = '{4'b1111, 32'h0C08_0400, 16'h2222, 8'h04, 4'b0010};
    vecs[4] = '{4'b1111, 32'h0C08_0400, 16'h3333, 8'h08, 4'b0100};
    vecs[5] = '{4'b1111, 32'h0C08_0400, 16'h4321, 8'h0C, 4'b1000};
    vecs[6] = '{4'b1111, 32'h0C08_0400, 16'h5555, 8'h00, 4'b0001};
    // After a reset: ch0 wins over ch1, then ch1.
    vecs[7] = '{4'b0011, 32'h0000_4A40, 16'h0A0A, 8'h40, 4'b0001};
    vecs[8] = '{4'b0010, 32'h0000_4A40, 16'h0B0B, 8'h4A, 4'b0010};
    // ch0/ch2 share 0x20, ch1 at 0x30.
`ifdef FETCH_ARB_BROADCAST_EN
    vecs[9]  = '{4'b0111, 32'h0020_3020, 16'hBEEF, 8'h20, 4'b0101};
    vecs[10] = '{4'b0010, 32'h0020_3020, 16'hCAFE, 8'h30, 4'b0010};
    n_vec = 11;
`else
    vecs[9]  = '{4'b0111, 32'h0020_3020, 16'hBEEF, 8'h20, 4'b0001};
    vecs[10] = '{4'b0110, 32'h0020_3020, 16'hCAFE, 8'h30, 4'b0010};
    vecs[11] = '{4'b0100, 32'h0020_3020, 16'hF00D, 8'h20, 4'b0100};
    n_vec = 12;
`endif

    reset = 1'b1;
    bus.consumer_read_valid   = '0;
    bus.consumer_read_address = '0;
    bus.mem_read_ready        = 1'b0;
    bus.mem_read_data         = '0;
    exp_bus = '0;
    tick();
    tick();
    check_idle_outputs("reset");
    reset = 1'b0;

    for (int i = 0; i <= 6; i++) run_vec(i);

    // Stalled memory: request and outputs must hold for 10 cycles.
    start_txn(4'b0010, 32'h0000_1C00, 8'h1C, "stall");
    for (int c = 0; c < 10; c++) begin
      tick();
      check($sformatf("stall c%0d mem valid", c), 64'(bus.mem_read_valid), 64'(1'b1));
      check($sformatf("stall c%0d mem addr", c), 64'(bus.mem_read_address), 64'(8'h1C));
      check($sformatf("stall c%0d ready", c), 64'(bus.consumer_read_ready), 64'(4'b0000));
    end
    finish_txn(16'h7777, 4'b0010, "stall");

    // Early drop: ch0 releases valid before the response; ready pulses one cycle.
    start_txn(4'b0001, 32'h0000_002C, 8'h2C, "drop");
    bus.consumer_read_valid = 4'b0000;
    tick();
    check("drop mem valid held", 64'(bus.mem_read_valid), 64'(1'b1));
    bus.mem_read_ready = 1'b1;
    bus.mem_read_data  = 16'h6060;
    tick();
    bus.mem_read_ready = 1'b0;
    exp_bus[0 +: D] = 16'h6060;
    check("drop ready pulse", 64'(bus.consumer_read_ready), 64'(4'b0001));
    check("drop data", 64'(bus.consumer_read_data), 64'(exp_bus));
    tick();
    check("drop ready one cycle", 64'(bus.consumer_read_ready), 64'(4'b0000));

    // Reset while ch3 is outstanding.
    start_txn(4'b1000, 32'h3C00_0000, 8'h3C, "rst_wait");
    reset = 1'b1;
    tick();
    exp_bus = '0;
    check_idle_outputs("rst_wait");
    reset = 1'b0;
    bus.consumer_read_valid = 4'b0000;
    for (int i = 7; i <= 8; i++) run_vec(i);

    // Idle reset pulse to restart the pointer at 0 for the shared-address case.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_bus = '0;
    check_idle_outputs("rst_idle");
    for (int i = 9; i < n_vec; i++) run_vec(i);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end
endmodule
